// File: rtl/led_status_ctrl.sv
// Drives player health bars, blink patterns and hit flashes onto a LED strip from the game FSM code.
// Latency: one clock from inputs to LEDvalues; the block has no backpressure and accepts inputs every cycle.
module led_status_ctrl #(
   parameter int NUM_LEDS   = 10,
   parameter int MAX_HP     = 3,
   parameter int HP_W       = 3,
   parameter int BLINK_HALF = 25000000,
   parameter int HIT_CYCLES = 12500000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [2:0]          game_state,
   input  logic [HP_W-1:0]     p1_health,
   input  logic [HP_W-1:0]     p2_health,
   output logic [NUM_LEDS-1:0] LEDvalues
);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_COUNTDOWN = 3'd1;
   localparam logic [2:0] ST_FIGHT     = 3'd2;
   localparam logic [2:0] ST_P1_WIN    = 3'd3;
   localparam logic [2:0] ST_P2_WIN    = 3'd4;
   localparam logic [2:0] ST_EQ        = 3'd5;

   localparam int CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam int TMR_W = $clog2(HIT_CYCLES + 1);

   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLINK_HALF - 1);
   localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(HIT_CYCLES);
   localparam logic [HP_W-1:0]   HP_MAX_V = HP_W'(MAX_HP);

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                phase_q, phase_d;
   logic [2:0]          prev_state_q;
   logic [HP_W-1:0]     prev1_q, prev2_q;
   logic [TMR_W-1:0]    tmr1_q, tmr1_d;
   logic [TMR_W-1:0]    tmr2_q, tmr2_d;
   logic [NUM_LEDS-1:0] led_q, led_d;

   logic                state_chg;
   logic                in_fight;
   logic                hit1, hit2;
   logic [HP_W-1:0]     hp1_c, hp2_c;
   logic [MAX_HP-1:0]   bar1, bar2;
   logic [MAX_HP-1:0]   p1_fld, p2_fld;
   logic                mid_bit;

   function automatic logic [MAX_HP-1:0] bar_of(input logic [HP_W-1:0] h);
      return ~({MAX_HP{1'b1}} >> h);
   endfunction

   function automatic logic [TMR_W-1:0] next_tmr(input logic fight,
                                                  input logic hit,
                                                  input logic [TMR_W-1:0] tmr);
      logic [TMR_W-1:0] nxt;
      nxt = '0;
      if (fight) begin
         if (hit)
            nxt = TMR_LOAD;
         else if (tmr != '0)
            nxt = tmr - TMR_W'(1);
      end
      return nxt;
   endfunction

   assign hp1_c    = (p1_health > HP_MAX_V) ? HP_MAX_V : p1_health;
   assign hp2_c    = (p2_health > HP_MAX_V) ? HP_MAX_V : p2_health;
   assign bar1     = bar_of(hp1_c);
   assign bar2     = bar_of(hp2_c);
   assign in_fight = (game_state == ST_FIGHT);

   // Health increases never count as hits; only a drop while fighting does.
   assign hit1 = in_fight && (hp1_c < prev1_q);
   assign hit2 = in_fight && (hp2_c < prev2_q);

   assign tmr1_d = next_tmr(in_fight, hit1, tmr1_q);
   assign tmr2_d = next_tmr(in_fight, hit2, tmr2_q);

   // A state change restarts the blink so every new pattern opens lit.
   always_comb begin
      state_chg = (game_state != prev_state_q);
      cnt_d     = cnt_q + CNT_W'(1);
      phase_d   = phase_q;
      if (state_chg) begin
         cnt_d   = '0;
         phase_d = 1'b1;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end
   end

   always_comb begin
      p1_fld  = '0;
      p2_fld  = '0;
      mid_bit = 1'b0;
      case (game_state)
         ST_COUNTDOWN, ST_EQ: begin
            p1_fld  = {MAX_HP{phase_d}};
            p2_fld  = {MAX_HP{phase_d}};
            mid_bit = phase_d;
         end
         ST_FIGHT: begin
            p1_fld = (tmr1_d != '0) ? ~bar1 : bar1;
            p2_fld = (tmr2_d != '0) ? ~bar2 : bar2;
         end
         ST_P1_WIN: begin
            p1_fld  = {MAX_HP{phase_d}};
            mid_bit = phase_d;
         end
         ST_P2_WIN: begin
            p2_fld  = {MAX_HP{phase_d}};
            mid_bit = phase_d;
         end
         default: begin
            p1_fld  = '0;
            p2_fld  = '0;
            mid_bit = 1'b0;
         end
      endcase
   end

   // Middle segment may be empty when NUM_LEDS == 2*MAX_HP.
   for (genvar g = 0; g < NUM_LEDS; g++) begin : g_led
      if (g >= NUM_LEDS - MAX_HP) begin : g_p1
         assign led_d[g] = p1_fld[g - (NUM_LEDS - MAX_HP)];
      end else if (g < MAX_HP) begin : g_p2
         assign led_d[g] = p2_fld[g];
      end else begin : g_mid
         assign led_d[g] = mid_bit;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         phase_q      <= 1'b0;
         prev_state_q <= ST_IDLE;
         prev1_q      <= '0;
         prev2_q      <= '0;
         tmr1_q       <= '0;
         tmr2_q       <= '0;
         led_q        <= '0;
      end else begin
         cnt_q        <= cnt_d;
         phase_q      <= phase_d;
         prev_state_q <= game_state;
         prev1_q      <= hp1_c;
         prev2_q      <= hp2_c;
         tmr1_q       <= tmr1_d;
         tmr2_q       <= tmr2_d;
         led_q        <= led_d;
      end
   end

   assign LEDvalues = led_q;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed bench for led_status_ctrl with a cycle-level reference model and literal spot checks.
module tb_led_status_ctrl;

   localparam int N  = 10;
   localparam int MH = 3;
   localparam int BH = 4;
   localparam int HC = 3;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [2:0]   game_state;
   logic [2:0]   p1_health;
   logic [2:0]   p2_health;
   logic [N-1:0] LEDvalues;

   int vectors     = 0;
   int miscompares = 0;

   led_status_ctrl #(
      .NUM_LEDS(N), .MAX_HP(MH), .HP_W(3), .BLINK_HALF(BH), .HIT_CYCLES(HC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .game_state(game_state),
      .p1_health(p1_health), .p2_health(p2_health), .LEDvalues(LEDvalues)
   );

   always #5 clk = ~clk;

   // Reference model: time since last state change gives the blink phase,
   // cycle stamp of the last hit gives the flash window.
   int         m_cyc     = 0;
   int         m_k       = 0;
   int         m_prev_gs = 0;
   int         m_prev_c1 = 0;
   int         m_prev_c2 = 0;
   int         m_last1   = -1000000;
   int         m_last2   = -1000000;
   logic [N-1:0] exp_led = '0;

   function automatic logic [N-1:0] expect_leds(input int gs, input bit ph,
                                                input int c1, input int c2,
                                                input bit i1, input bit i2);
      int fm, p1m, p2m, midm, b1, b2, v;
      fm   = (1 << MH) - 1;
      p1m  = fm << (N - MH);
      p2m  = fm;
      midm = ((1 << N) - 1) & ~p1m & ~p2m;
      b1   = ((1 << c1) - 1) << (MH - c1);
      b2   = ((1 << c2) - 1) << (MH - c2);
      if (i1) b1 = ~b1 & fm;
      if (i2) b2 = ~b2 & fm;
      case (gs)
         2:       v = (b1 << (N - MH)) | b2;
         1, 5:    v = ph ? ((1 << N) - 1) : 0;
         3:       v = ph ? (p1m | midm) : 0;
         4:       v = ph ? (p2m | midm) : 0;
         default: v = 0;
      endcase
      return N'(v);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      int  gs, c1, c2;
      bit  ph, i1, i2;
      if (!rst_n) begin
         m_k       = 0;
         m_prev_gs = 0;
         m_prev_c1 = 0;
         m_prev_c2 = 0;
         m_last1   = -1000000;
         m_last2   = -1000000;
         exp_led   = '0;
      end else begin
         m_cyc++;
         gs = int'(game_state);
         c1 = (int'(p1_health) > MH) ? MH : int'(p1_health);
         c2 = (int'(p2_health) > MH) ? MH : int'(p2_health);
         if (gs != m_prev_gs) m_k = 0;
         else                 m_k++;
         m_prev_gs = gs;
         ph = ((m_k / BH) % 2) == 0;
         if (gs == 2) begin
            if (c1 < m_prev_c1) m_last1 = m_cyc;
            if (c2 < m_prev_c2) m_last2 = m_cyc;
         end else begin
            m_last1 = -1000000;
            m_last2 = -1000000;
         end
         i1 = (gs == 2) && (m_cyc - m_last1 < HC);
         i2 = (gs == 2) && (m_cyc - m_last2 < HC);
         m_prev_c1 = c1;
         m_prev_c2 = c2;
         exp_led = expect_leds(gs, ph, c1, c2, i1, i2);
      end
   end

   always @(negedge clk) begin
      vectors++;
      if (LEDvalues !== exp_led) begin
         miscompares++;
         $display("FAIL model t=%0t LEDvalues=%b expected=%b", $time, LEDvalues, exp_led);
      end
   end

   task automatic chk(input string name, input logic [N-1:0] exp);
      vectors++;
      if (LEDvalues !== exp) begin
         miscompares++;
         $display("FAIL %s: LEDvalues=%b expected=%b", name, LEDvalues, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; game_state = 3'd0; p1_health = 3'd0; p2_health = 3'd0;
      @(negedge clk); #1 chk("reset", 10'b0);
      @(negedge clk); rst_n = 1'b1;
      step(1); chk("idle_after_reset", 10'b0);

      game_state = 3'd2; p1_health = 3'd3; p2_health = 3'd1;
      step(1); chk("fight_3_1", 10'b1110000100);
      p1_health = 3'd7;
      step(1); chk("clamp_p1_7", 10'b1110000100);
      p1_health = 3'd3; p2_health = 3'd3;
      step(1); chk("heal_no_flash", 10'b1110000111);

      p2_health = 3'd2;
      for (int i = 0; i < 3; i++) begin
         step(1); chk($sformatf("p2_flash[%0d]", i), 10'b1110000001);
      end
      step(1); chk("p2_flash_end", 10'b1110000110);

      p1_health = 3'd2;
      step(1); chk("p1_hit_a0", 10'b0010000110);
      step(1); chk("p1_hit_a1", 10'b0010000110);
      p1_health = 3'd1;
      for (int i = 0; i < 3; i++) begin
         step(1); chk($sformatf("p1_reload[%0d]", i), 10'b0110000110);
      end
      step(1); chk("p1_reload_end", 10'b1000000110);

      game_state = 3'd0;
      step(1); chk("idle", 10'b0);
      game_state = 3'd1;
      for (int i = 0; i < 16; i++) begin
         step(1);
         chk($sformatf("countdown[%0d]", i), ((i / 4) % 2 == 0) ? 10'b1111111111 : 10'b0);
      end

      game_state = 3'd2; p1_health = 3'd3; p2_health = 3'd3;
      step(1); chk("fight_full", 10'b1110000111);
      p2_health = 3'd2;
      step(1); chk("flash_before_idle", 10'b1110000001);
      game_state = 3'd0;
      step(1); chk("idle_mid_flash", 10'b0);
      game_state = 3'd2;
      step(1); chk("timers_cleared", 10'b1110000110);

      game_state = 3'd4;
      for (int i = 0; i < 12; i++) begin
         step(1);
         chk($sformatf("p2_win[%0d]", i), ((i / 4) % 2 == 0) ? 10'b0001111111 : 10'b0);
      end
      game_state = 3'd3;
      step(1); chk("p1_win", 10'b1111111000);
      step(5);
      game_state = 3'd5; step(5);
      game_state = 3'd6; step(1); chk("code6", 10'b0);
      game_state = 3'd7; step(2);

      game_state = 3'd1;
      step(1); chk("cd_lit", 10'b1111111111);
      step(1);
      #2 rst_n = 1'b0;
      #1 chk("async_reset", 10'b0);
      @(negedge clk);
      game_state = 3'd2; p1_health = 3'd3; p2_health = 3'd3; rst_n = 1'b1;
      step(1); chk("post_reset_fight", 10'b1110000111);
      step(1); chk("post_reset_fight_hold", 10'b1110000111);

      p1_health = 3'd1;
      step(1); chk("flash_before_reset", 10'b0110000111);
      #2 rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      step(1); chk("post_reset_no_flash", 10'b1000000111);
      step(4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/led_status_ctrl.md
LED_STATUS_CTRL -- requirements
Module: led_status_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_LEDS, default 10: total LED count; legal when NUM_LEDS >= 2*MAX_HP.
REQ-002 The block SHALL have parameter MAX_HP, default 3: LEDs per player health bar and the health clamp ceiling.
REQ-003 The block SHALL have parameter HP_W, default 3: width of each health input.
REQ-004 The block SHALL have parameter BLINK_HALF, default 25000000: clock cycles per blink half-period; legal when >= 1.
REQ-005 The block SHALL have parameter HIT_CYCLES, default 12500000: length in clocks of the hit-flash window; legal when >= 1.
REQ-006 The block SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-007 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 The block SHALL have port game_state  input  3  game FSM code: 0 IDLE, 1 COUNTDOWN, 2 FIGHT, 3 P1_WIN, 4 P2_WIN, 5 EQ; 6 and 7 are undefined.
REQ-009 The block SHALL have port p1_health  input  HP_W  player-1 remaining lives.
REQ-010 The block SHALL have port p2_health  input  HP_W  player-2 remaining lives.
REQ-011 The block SHALL have port LEDvalues  output  NUM_LEDS  registered LED drive; 1 = lit.

Function
REQ-012 Field map SHALL be: P1 field = LEDvalues[NUM_LEDS-1 : NUM_LEDS-MAX_HP]; P2 field = LEDvalues[MAX_HP-1 : 0]; middle = all remaining bits (possibly none).
REQ-013 Health SHALL be clamped: values > MAX_HP display as MAX_HP.
REQ-014 Bar SHALL fill from the field MSB downward: health h lights the top h bits of its field. Example, MAX_HP=3: 3->111, 2->110, 1->100, 0->000.
REQ-015 Blink generator SHALL be a counter 0..BLINK_HALF-1 that wraps to 0; the blink phase toggles on each wrap.
REQ-016 Any change of game_state between consecutive clocks SHALL clear the counter and set the phase to 1 (lit) on that edge.
REQ-017 IDLE SHALL drive all LEDs off.
REQ-018 FIGHT SHALL drive P1 bar, P2 bar, and middle off, subject to the hit flash in REQ-021..024.
REQ-019 COUNTDOWN and EQ SHALL drive every LED equal to the blink phase.
REQ-020 P1_WIN SHALL drive P1 field and middle at the blink phase with P2 field off; P2_WIN SHALL mirror this. Codes 6 and 7 SHALL drive all LEDs off.
REQ-021 Per player, a prev-health register SHALL capture the clamped health every cycle, in every state.
REQ-022 In FIGHT, when clamped health < prev, that player's hit timer SHALL load HIT_CYCLES.
REQ-023 A nonzero timer SHALL decrement by 1 per cycle. A new hit while the timer is nonzero SHALL reload it to HIT_CYCLES. A health increase SHALL NOT load the timer.
REQ-024 While the timer is nonzero or loading this cycle, that player's field SHALL show the bitwise inverse of its bar. The inverted field therefore appears on the first edge after the drop and lasts exactly HIT_CYCLES clocks. The two players' timers SHALL be independent.
REQ-025 Leaving FIGHT SHALL clear both hit timers on the same edge.
REQ-026 Latency: LEDvalues SHALL reflect inputs sampled on the previous rising edge (1-cycle registered output).

Reset
REQ-027 While rst_n = 0, the block SHALL immediately force LEDvalues = 0, counter = 0, phase = 0, both timers = 0, and both prev-health registers = 0. Because prev-health resets to 0, the first health sample after reset SHALL NOT trigger a hit.
REQ-028 After reset, the previous-state tracker SHALL be IDLE, so an initial state other than IDLE counts as a change under REQ-016.
REQ-029 Reset asserted mid-flash or mid-blink SHALL abort all activity; there SHALL be no residual effect after release.

Verification (NUM_LEDS=10, MAX_HP=3, BLINK_HALF=4, HIT_CYCLES=3)
REQ-030 The bench SHALL cover: FIGHT, p1=3, p2=1 -> LEDvalues = 10'b1110000100 one cycle later; p1=7 -> P1 field 111 (clamp).
REQ-031 The bench SHALL cover: IDLE->COUNTDOWN -> all-ones for 4 cycles, then all-zeros for 4, then all-ones, repeating with period 8.
REQ-032 The bench SHALL cover: FIGHT, p2 3->2 -> P2 field 001 for exactly 3 cycles, then 110; P1 field unaffected.
REQ-033 The bench SHALL cover: p1 3->2, then 2->1 two cycles later -> P1 field 001, 001, 011, 011, 011, then 100 (timer reloaded).
REQ-034 The bench SHALL cover: P2_WIN -> LEDvalues toggles between 10'b0001111111 and 0 every 4 cycles; switching to IDLE mid-flash -> 0 next cycle with timers cleared.
REQ-035 The bench SHALL cover: rst_n low asynchronously during a lit blink -> LEDvalues = 0 before the next edge; after release in FIGHT with p1=p2=3 -> 10'b1110000111 with no inversion.
